// File: rtl/frame_scanout_if.sv
// Frame-buffer read port between the scan-out engine (master) and the
// dual-bank pixel memory (slave).
interface frame_scanout_if;
  logic [15:0] fb_rd_addr;
  logic        fb_rd_en;
  logic [1:0]  fb_rd_data;

  modport master (output fb_rd_addr, output fb_rd_en, input fb_rd_data);
  modport slave  (input fb_rd_addr, input fb_rd_en, output fb_rd_data);
endinterface

// File: rtl/frame_scanout.sv
// VGA scan-out of the PPU frame buffer: 3x upscale into a centred window,
// palette-mapped grey, double-buffer bank swap at frame end.
module frame_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_OFF    = 80,
  parameter int Y_OFF    = 24,
  parameter int FB_W     = 160,
  parameter int FB_H     = 144,
  parameter int RD_LAT   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  frame_scanout_if.master       fb,
  input  logic [7:0]            palette,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  display_bank,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [7:0]            grey
);

  localparam logic [9:0]  H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0]  WX_BEG    = 10'(X_OFF);
  localparam logic [9:0]  WX_END    = 10'(X_OFF + 3 * FB_W);
  localparam logic [9:0]  WY_BEG    = 10'(Y_OFF);
  localparam logic [9:0]  WY_END    = 10'(Y_OFF + 3 * FB_H);
  localparam logic [7:0]  FBX_LAST  = 8'(FB_W - 1);
  localparam logic [7:0]  FBY_LAST  = 8'(FB_H - 1);
  localparam logic [15:0] BANK_SIZE = 16'(FB_W * FB_H);
  localparam logic [15:0] ROW_PITCH = 16'(FB_W);

  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]  xs_q, xs_d, ys_q, ys_d;
  logic [7:0]  fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [15:0] addr_hold_q, addr_c;
  logic [7:0]  pal_q;
  logic        bank_q, swap_ack_q;
  logic        line_end, frame_end;
  logic        win_h, win_v, win;
  logic        hs_raw, vs_raw, de_raw;

  always_comb begin
    line_end  = (h_cnt_q == H_LAST);
    frame_end = line_end && (v_cnt_q == V_LAST);
    h_cnt_d   = line_end ? '0 : h_cnt_q + 10'd1;
    v_cnt_d   = v_cnt_q;
    if (line_end) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;

    win_h  = (h_cnt_q >= WX_BEG) && (h_cnt_q < WX_END);
    win_v  = (v_cnt_q >= WY_BEG) && (v_cnt_q < WY_END);
    win    = win_h && win_v;
    hs_raw = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_raw = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    de_raw = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  end

  // 3x scaling by sub-counters: each source pixel/line is repeated three times.
  always_comb begin
    xs_d   = xs_q;
    fb_x_d = fb_x_q;
    ys_d   = ys_q;
    fb_y_d = fb_y_q;
    if (h_cnt_d == WX_BEG) begin
      xs_d   = '0;
      fb_x_d = '0;
    end else if (win_h) begin
      if (xs_q == 2'd2) begin
        xs_d   = '0;
        fb_x_d = (fb_x_q == FBX_LAST) ? '0 : fb_x_q + 8'd1;
      end else begin
        xs_d = xs_q + 2'd1;
      end
    end
    if (line_end) begin
      if (v_cnt_d == WY_BEG) begin
        ys_d   = '0;
        fb_y_d = '0;
      end else if (win_v) begin
        if (ys_q == 2'd2) begin
          ys_d   = '0;
          fb_y_d = (fb_y_q == FBY_LAST) ? '0 : fb_y_q + 8'd1;
        end else begin
          ys_d = ys_q + 2'd1;
        end
      end
    end
  end

  assign addr_c = (bank_q ? BANK_SIZE : 16'd0) + 16'(fb_y_q) * ROW_PITCH + 16'(fb_x_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      fb_x_q      <= '0;
      fb_y_q      <= '0;
      addr_hold_q <= '0;
      pal_q       <= '0;
      bank_q      <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      if (win) addr_hold_q <= addr_c;
      if (h_cnt_q == '0) pal_q <= palette;
      // Bank only flips on the last clock of the frame so a frame is never torn.
      if (frame_end && swap_req) bank_q <= ~bank_q;
      swap_ack_q <= frame_end && swap_req;
    end
  end

  assign fb.fb_rd_en   = win;
  assign fb.fb_rd_addr = win ? addr_c : addr_hold_q;

  // Timing taps ride alongside the memory read: {win, de, vsync, hsync}.
  logic [3:0] tap_c, dly;
  logic [3:0] pipe_q [RD_LAT];
  logic [1:0] shade;
  logic [7:0] lut, grey_d;
  logic       hsync_q, vsync_q, de_q;
  logic [7:0] grey_q;

  assign tap_c = {win, de_raw, vs_raw, hs_raw};
  assign dly   = pipe_q[RD_LAT-1];

  always_comb begin
    shade = pal_q[{fb.fb_rd_data, 1'b0} +: 2];
    case (shade)
      2'd0:    lut = 8'hFF;
      2'd1:    lut = 8'hAA;
      2'd2:    lut = 8'h55;
      default: lut = 8'h00;
    endcase
    grey_d = (dly[3] && dly[2]) ? lut : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= 4'b0011;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      grey_q  <= '0;
    end else begin
      pipe_q[0] <= tap_c;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      hsync_q <= dly[0];
      vsync_q <= dly[1];
      de_q    <= dly[2];
      grey_q  <= grey_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign grey         = grey_q;
  assign display_bank = bank_q;
  assign swap_ack     = swap_ack_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench: full-size instance for raster/address/palette/reset, a
// shrunken-raster instance (RD_LAT=2) for frame-end bank swap and vsync.
module tb_frame_scanout;
  logic       clock = 1'b0;
  logic       rst_b_n, rst_s_n;
  logic [7:0] pal_b, pal_s;
  logic       swap_b, swap_s;
  logic       ack_b, ack_s, bank_b, bank_s;
  logic       hs_b, hs_s, vs_b, vs_s, de_b, de_s;
  logic [7:0] grey_b, grey_s;
  logic [1:0] s_d1 = 2'd0;
  int         checks = 0;
  int         failures = 0;
  int         k = 0;

  frame_scanout_if fb_b ();
  frame_scanout_if fb_s ();

  always #5 clock = ~clock;

  frame_scanout u_big (
    .clock(clock), .reset_n(rst_b_n), .fb(fb_b.master), .palette(pal_b),
    .swap_req(swap_b), .swap_ack(ack_b), .display_bank(bank_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .grey(grey_b));

  // 56x37 raster, window x[8,32) y[4,22), 8x6 frame buffer.
  frame_scanout #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .X_OFF(8), .Y_OFF(4), .FB_W(8), .FB_H(6), .RD_LAT(2)
  ) u_small (
    .clock(clock), .reset_n(rst_s_n), .fb(fb_s.master), .palette(pal_s),
    .swap_req(swap_s), .swap_ack(ack_s), .display_bank(bank_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .grey(grey_s));

  // Memory content: pixel code = fb_x[1:0] in either bank.
  function automatic logic [1:0] code_of(input logic [15:0] a, input int bank, input int w);
    int off;
    off = int'(a) % bank;
    return 2'(off % w);
  endfunction

  always @(posedge clock) fb_b.fb_rd_data <= code_of(fb_b.fb_rd_addr, 23040, 160);
  always @(posedge clock) begin
    s_d1 <= code_of(fb_s.fb_rd_addr, 48, 8);
    fb_s.fb_rd_data <= s_d1;
  end

  // k = clock edges since the active instance left reset = its raster counter.
  task automatic tick_to(input int target);
    repeat (target - k) @(posedge clock);
    #1;
    k = target;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_b_n = 1'b0; rst_s_n = 1'b0;
    pal_b = 8'hE4; pal_s = 8'hE4;
    swap_b = 1'b0; swap_s = 1'b0;
    #12;
    chk("rst_hsync", 16'(hs_b), 16'd1);
    chk("rst_vsync", 16'(vs_b), 16'd1);
    chk("rst_de", 16'(de_b), 16'd0);
    chk("rst_grey", 16'(grey_b), 16'd0);
    chk("rst_bank", 16'(bank_b), 16'd0);
    chk("rst_ack", 16'(ack_b), 16'd0);
    chk("rst_rd_en", 16'(fb_b.fb_rd_en), 16'd0);
    #11;
    rst_b_n = 1'b1;
    k = 0;

    // Window pixels on line 24, observed two clocks after the counter.
    tick_to(24*800 + 79 + 2);  chk("border_79", 16'(grey_b), 16'h00);
                               chk("border_79_de", 16'(de_b), 16'd1);
    tick_to(24*800 + 80 + 2);  chk("px_80_24", 16'(grey_b), 16'hFF);
    tick_to(24*800 + 82 + 2);  chk("px_82_24", 16'(grey_b), 16'hFF);
    tick_to(24*800 + 83 + 2);  chk("px_83_24", 16'(grey_b), 16'hAA);
    tick_to(24*800 + 86 + 2);  chk("px_86_24", 16'(grey_b), 16'h55);
    tick_to(24*800 + 92 + 2);  chk("px_92_24", 16'(grey_b), 16'hFF);

    // Addresses are combinational on the counter.
    tick_to(27*800 + 79);      chk("rd_en_79_27", 16'(fb_b.fb_rd_en), 16'd0);
    tick_to(27*800 + 83);      chk("addr_83_27", fb_b.fb_rd_addr, 16'd161);
                               chk("rd_en_83_27", 16'(fb_b.fb_rd_en), 16'd1);
    tick_to(27*800 + 560);     chk("addr_hold_560_27", fb_b.fb_rd_addr, 16'd319);
                               chk("rd_en_560_27", 16'(fb_b.fb_rd_en), 16'd0);

    // Horizontal timing edges on line 30.
    tick_to(30*800 + 639 + 2); chk("de_639", 16'(de_b), 16'd1);
    tick_to(30*800 + 640 + 2); chk("de_640", 16'(de_b), 16'd0);
    tick_to(30*800 + 655 + 2); chk("hs_655", 16'(hs_b), 16'd1);
                               chk("vs_line30", 16'(vs_b), 16'd1);
    tick_to(30*800 + 656 + 2); chk("hs_656", 16'(hs_b), 16'd0);
    tick_to(30*800 + 751 + 2); chk("hs_751", 16'(hs_b), 16'd0);
    tick_to(30*800 + 752 + 2); chk("hs_752", 16'(hs_b), 16'd1);

    // Mid-line palette change applies from the next line.
    tick_to(50*800 + 300);     pal_b = 8'h1B;
    tick_to(50*800 + 500 + 2); chk("pal_old_500_50", 16'(grey_b), 16'hFF);
    tick_to(50*800 + 503 + 2); chk("pal_old_503_50", 16'(grey_b), 16'hAA);
    tick_to(51*800 + 80 + 2);  chk("pal_new_80_51", 16'(grey_b), 16'h00);
    tick_to(51*800 + 83 + 2);  chk("pal_new_83_51", 16'(grey_b), 16'h55);
    tick_to(51*800 + 500 + 2); chk("pal_new_500_51", 16'(grey_b), 16'h00);
    tick_to(51*800 + 559 + 2); chk("pal_new_559_51", 16'(grey_b), 16'hFF);

    // Asynchronous reset between clock edges.
    #2 rst_b_n = 1'b0;
    #1;
    chk("arst_grey", 16'(grey_b), 16'h00);
    chk("arst_de", 16'(de_b), 16'd0);
    chk("arst_hsync", 16'(hs_b), 16'd1);
    chk("arst_vsync", 16'(vs_b), 16'd1);
    chk("arst_bank", 16'(bank_b), 16'd0);
    rst_b_n = 1'b1;
    k = 0;
    tick_to(657);              chk("arst_hs_657", 16'(hs_b), 16'd1);
    tick_to(658);              chk("arst_hs_658", 16'(hs_b), 16'd0);

    // Shrunken raster: 56 clocks/line, 2072 clocks/frame, latency 3.
    rst_s_n = 1'b1;
    k = 0;
    chk("s_rst_ack", 16'(ack_s), 16'd0);
    tick_to(4*56 + 8 + 2);     chk("s_px_early", 16'(grey_s), 16'h00);
    tick_to(4*56 + 8 + 3);     chk("s_px_8_4", 16'(grey_s), 16'hFF);
    tick_to(4*56 + 11 + 3);    chk("s_px_11_4", 16'(grey_s), 16'hAA);
    tick_to(10*56);            swap_s = 1'b1;
                               chk("s_bank_midframe", 16'(bank_s), 16'd0);
    tick_to(21*56 + 31);       chk("s_addr_last", fb_s.fb_rd_addr, 16'd47);
    tick_to(32*56 + 2);        chk("s_vs_before", 16'(vs_s), 16'd1);
    tick_to(32*56 + 3);        chk("s_vs_fall", 16'(vs_s), 16'd0);
    tick_to(34*56 + 2);        chk("s_vs_last", 16'(vs_s), 16'd0);
    tick_to(34*56 + 3);        chk("s_vs_rise", 16'(vs_s), 16'd1);
    tick_to(2071);             chk("s_bank_pre", 16'(bank_s), 16'd0);
                               chk("s_ack_pre", 16'(ack_s), 16'd0);
    tick_to(2072);             chk("s_bank_swap1", 16'(bank_s), 16'd1);
                               chk("s_ack_swap1", 16'(ack_s), 16'd1);
    tick_to(2073);             chk("s_ack_one_cycle", 16'(ack_s), 16'd0);
    tick_to(2072 + 4*56 + 8);  chk("s_addr_bank1", fb_s.fb_rd_addr, 16'd48);
    tick_to(2072 + 4*56 + 11); chk("s_px_bank1", 16'(grey_s), 16'hFF);
    tick_to(4143);             chk("s_bank_hold", 16'(bank_s), 16'd1);
    tick_to(4144);             chk("s_bank_swap2", 16'(bank_s), 16'd0);
                               chk("s_ack_swap2", 16'(ack_s), 16'd1);
    tick_to(4145);             swap_s = 1'b0;
    tick_to(6216);             chk("s_bank_noswap", 16'(bank_s), 16'd0);
                               chk("s_ack_noswap", 16'(ack_s), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
